vga_bitmap_scanner: RTL
=======================

// Module: vga_bitmap_scanner
// PURPOSE
//  Consumer of the data memory's video read port (av/clkv/Rdv). Generates VGA timing,
//  scans a 1-bit-per-pixel bitmap stored MSB-first in 32-bit memory words, and drives
//  sync plus 8-bit RRRGGGBB colour. Sits between Data_Memory's second port and the
//  board VGA pins. clkv is tied to CLK at top level, so Rdv is valid 1 cycle after av.
// PARAMETERS
//  H_VISIBLE 640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_VISIBLE 480  visible lines
//  V_FP      10 | V_SYNC 2 | V_BP 33   vertical porch/sync lines
//  BMP_W     64   bitmap width in pixels; multiple of 32
//  BMP_H     32   bitmap height in pixels; BMP_W*BMP_H/32 <= 64 words
//  SCALE     10   each bitmap pixel drawn as SCALE x SCALE screen pixels
// PORTS
//  CLK         in   1   pixel clock (25 MHz for defaults)
//  RST         in   1   synchronous active-high reset
//  Rdv         in   32  word read from memory video port
//  fg_color    in   8   colour for bit=1
//  bg_color    in   8   colour for bit=0 and for visible area outside the bitmap
//  av          out  32  word index to memory video port; word index, not byte address
//  hsync       out  1   active-low horizontal sync
//  vsync       out  1   active-low vertical sync
//  rgb         out  8   RRRGGGBB pixel; 0 outside the visible area
//  active      out  1   high when rgb is a visible pixel
//  frame_start out  1   1-cycle pulse aligned with the first visible pixel (0,0)
// BEHAVIOUR
//  - RST: all outputs are forced to the following values on the next CLK edge:
//    hcount=vcount=0, av=0, hsync=vsync=1, rgb=0, active=0, frame_start=0;
//    all pipeline regs are cleared. Reset mid-frame restarts at pixel (0,0) of a new frame.
//  - hcount counts 0..H_TOTAL-1 and wraps to 0. H_TOTAL = sum of the four H params.
//  - vcount increments when hcount wraps and counts 0..V_TOTAL-1. At (H_TOTAL-1, V_TOTAL-1)
//    both counters wrap to 0 in the same cycle.
//  - hsync is low for hcount in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1].
//    vsync uses the same rule on vcount with the V params.
//  - Bitmap coordinates bx = hcount/SCALE and by = vcount/SCALE come from prescale
//    sub-counters. No dividers.
//  - in_bmp = (hcount < BMP_W*SCALE) && (vcount < BMP_H*SCALE).
//  - Pipeline: 3 cycles fixed from counter state to outputs.
//    S1: register av = by*(BMP_W/32) + bx/32 when in_bmp, else av=0.
//    S2: memory returns Rdv for av. Bit index 31-(bx%32) is delayed alongside.
//    S3: register rgb, active, hsync, vsync and frame_start.
//    All sync, active and in_bmp flags are delayed 3 stages, so they align with rgb.
//  - rgb = 0 when not visible; bg_color when visible and not in_bmp;
//    otherwise Rdv[bit] ? fg_color : bg_color.
//  - fg_color/bg_color are sampled at S3; a change takes effect on the next pixel.
//  - The bitmap is never read outside in_bmp. av stays 0 during blanking.
// CONFIGURATION
//  VGA_SCAN_BORDER_EN defined: visible pixels with hcount==0, hcount==H_VISIBLE-1,
//    vcount==0 or vcount==V_VISIBLE-1 are forced to fg_color. This overrides bitmap
//    and bg rules; timing and latency are unchanged.
//  VGA_SCAN_BORDER_EN undefined: no border logic; edge pixels follow the normal rules.
// TESTING
//  1. RST=1 for 3 cycles, then release -> during reset hsync=vsync=1, rgb=0, active=0, av=0;
//     first frame_start 3 cycles after release.
//  2. Free run 2 frames -> hsync low 96 cycles every 800; vsync low 2 lines every 525;
//     frame_start period = 420000 cycles.
//  3. RAM[0]=32'h8000_0001, fg=8'hE0, bg=8'h03 -> line 0 pixels 0-9 = E0, 10-309 = 03,
//     310-319 = E0, 640-horizontal-pixel line beyond 639 -> rgb=0.
//  4. RAM[3]=32'hFFFF_FFFF -> screen rows 10-19, x 320-639 = fg; av sequence on
//     row 10 = 2 then 3, each changing every 320 cycles.
//  5. Assert RST at hcount=200, vcount=100 for 1 cycle -> counters restart at 0;
//     next frame_start 3 cycles after release; no partial-frame pulse.
//  6. Build with VGA_SCAN_BORDER_EN, memory all 0, fg=8'hFF, bg=8'h00 -> rows 0 and 479
//     and columns 0 and 639 = FF; all other visible pixels = 00.

Source files
------------

// File: rtl/vga_bitmap_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : vga_bitmap_scanner
//  Purpose  : VGA timing generator and 1-bpp bitmap scanner. Walks the raster,
//             fetches 32-bit bitmap words (MSB = leftmost pixel) through the
//             data memory's video read port and drives sync plus RRRGGGBB
//             colour. Each bitmap pixel covers SCALE x SCALE screen pixels.
//  Ports    : CLK          pixel clock
//             RST          synchronous active-high reset
//             Rdv[31:0]    memory word, valid one cycle after av
//             fg_color[7:0] colour for bitmap bit = 1
//             bg_color[7:0] colour for bit = 0 and visible area off-bitmap
//             av[31:0]     word index into the bitmap (not a byte address)
//             hsync/vsync  active-low syncs
//             rgb[7:0]     pixel colour, 0 outside the visible area
//             active       rgb is a visible pixel
//             frame_start  one-cycle pulse with pixel (0,0)
//  Options  : VGA_SCAN_BORDER_EN - when defined, the outermost visible rows
//             and columns are painted fg_color regardless of the bitmap.
//  Revision : 1.0  initial release
// ============================================================================
module vga_bitmap_scanner #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int BMP_W     = 64,
  parameter int BMP_H     = 32,
  parameter int SCALE     = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Rdv,
  input  logic [7:0]  fg_color,
  input  logic [7:0]  bg_color,
  output logic [31:0] av,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  rgb,
  output logic        active,
  output logic        frame_start
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int H_TOTAL       = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL       = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW            = $clog2(H_TOTAL);
  localparam int VW            = $clog2(V_TOTAL);
  localparam int SW            = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int BXW_RAW       = $clog2((H_TOTAL - 1) / SCALE + 1);
  localparam int BXW           = (BXW_RAW < 5) ? 5 : BXW_RAW;
  localparam int BYW_RAW       = $clog2((V_TOTAL - 1) / SCALE + 1);
  localparam int BYW           = (BYW_RAW < 1) ? 1 : BYW_RAW;
  localparam int WORDS_PER_ROW = BMP_W / 32;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_BMP_END = HW'(BMP_W * SCALE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_BMP_END = VW'(BMP_H * SCALE);
  localparam logic [SW-1:0] SUB_LAST  = SW'(SCALE - 1);

`ifdef VGA_SCAN_BORDER_EN
  localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VISIBLE - 1);
  localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VISIBLE - 1);
`endif

  // --------------------------------------------------------------------------
  // Raster counters with prescaled bitmap coordinates
  // --------------------------------------------------------------------------
  logic [HW-1:0]  hcount_q, hcount_d;
  logic [VW-1:0]  vcount_q, vcount_d;
  logic [SW-1:0]  hsub_q, hsub_d;
  logic [SW-1:0]  vsub_q, vsub_d;
  logic [BXW-1:0] bx_q, bx_d;
  logic [BYW-1:0] by_q, by_d;

  logic h_wrap, v_wrap;

  // bx/by advance once per SCALE pixels/lines, so they equal hcount/SCALE
  // and vcount/SCALE without any division hardware.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = hcount_q + HW'(1);
    hsub_d   = hsub_q + SW'(1);
    bx_d     = bx_q;
    vcount_d = vcount_q;
    vsub_d   = vsub_q;
    by_d     = by_q;

    if (h_wrap) begin
      hcount_d = '0;
      hsub_d   = '0;
      bx_d     = '0;
    end else if (hsub_q == SUB_LAST) begin
      hsub_d = '0;
      bx_d   = bx_q + BXW'(1);
    end

    if (h_wrap) begin
      if (v_wrap) begin
        vcount_d = '0;
        vsub_d   = '0;
        by_d     = '0;
      end else begin
        vcount_d = vcount_q + VW'(1);
        if (vsub_q == SUB_LAST) begin
          vsub_d = '0;
          by_d   = by_q + BYW'(1);
        end else begin
          vsub_d = vsub_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsub_q   <= '0;
      vsub_q   <= '0;
      bx_q     <= '0;
      by_q     <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsub_q   <= hsub_d;
      vsub_q   <= vsub_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel classification for the current counter state
  // --------------------------------------------------------------------------
  logic        w_vis, w_in_bmp, w_hs_n, w_vs_n, w_fs;
  logic [4:0]  w_bit;
  logic [31:0] w_av;

  always_comb begin
    w_vis    = (hcount_q < H_VIS_END) && (vcount_q < V_VIS_END);
    w_in_bmp = (hcount_q < H_BMP_END) && (vcount_q < V_BMP_END);
    w_hs_n   = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
    w_vs_n   = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
    w_fs     = (hcount_q == '0) && (vcount_q == '0);
    // 31 - (bx % 32) is the bitwise inverse of the low five bits.
    w_bit    = ~bx_q[4:0];
    // Off-bitmap pixels hold av at 0 so memory is never scanned outside it.
    w_av     = '0;
    if (w_in_bmp) begin
      w_av = 32'(by_q) * 32'(WORDS_PER_ROW) + (32'(bx_q) >> 5);
    end
  end

`ifdef VGA_SCAN_BORDER_EN
  logic w_border;
  always_comb begin
    w_border = (hcount_q == '0) || (hcount_q == H_VIS_LAST) ||
               (vcount_q == '0) || (vcount_q == V_VIS_LAST);
  end
`endif

  // --------------------------------------------------------------------------
  // S1: address register plus delayed flags
  // S2: memory answers on Rdv; flags follow
  // --------------------------------------------------------------------------
  logic [31:0] av_q;
  logic        s1_vis_q, s1_in_bmp_q, s1_hs_q, s1_vs_q, s1_fs_q;
  logic [4:0]  s1_bit_q;
  logic        s2_vis_q, s2_in_bmp_q, s2_hs_q, s2_vs_q, s2_fs_q;
  logic [4:0]  s2_bit_q;
`ifdef VGA_SCAN_BORDER_EN
  logic        s1_border_q, s2_border_q;
`endif

  // Sync flags reset to 1 (inactive) so the outputs read high through reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      av_q        <= '0;
      s1_vis_q    <= 1'b0;
      s1_in_bmp_q <= 1'b0;
      s1_hs_q     <= 1'b1;
      s1_vs_q     <= 1'b1;
      s1_fs_q     <= 1'b0;
      s1_bit_q    <= '0;
      s2_vis_q    <= 1'b0;
      s2_in_bmp_q <= 1'b0;
      s2_hs_q     <= 1'b1;
      s2_vs_q     <= 1'b1;
      s2_fs_q     <= 1'b0;
      s2_bit_q    <= '0;
    end else begin
      av_q        <= w_av;
      s1_vis_q    <= w_vis;
      s1_in_bmp_q <= w_in_bmp;
      s1_hs_q     <= w_hs_n;
      s1_vs_q     <= w_vs_n;
      s1_fs_q     <= w_fs;
      s1_bit_q    <= w_bit;
      s2_vis_q    <= s1_vis_q;
      s2_in_bmp_q <= s1_in_bmp_q;
      s2_hs_q     <= s1_hs_q;
      s2_vs_q     <= s1_vs_q;
      s2_fs_q     <= s1_fs_q;
      s2_bit_q    <= s1_bit_q;
    end
  end

`ifdef VGA_SCAN_BORDER_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_border_q <= 1'b0;
      s2_border_q <= 1'b0;
    end else begin
      s1_border_q <= w_border;
      s2_border_q <= s1_border_q;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // S3: colour select and output registers
  // --------------------------------------------------------------------------
  logic [7:0] rgb_q, rgb_d;
  logic       active_q, hsync_q, vsync_q, fs_q;
  logic       w_pix_border;

`ifdef VGA_SCAN_BORDER_EN
  assign w_pix_border = s2_border_q;
`else
  assign w_pix_border = 1'b0;
`endif

  always_comb begin
    rgb_d = '0;
    if (s2_vis_q) begin
      if (w_pix_border) begin
        rgb_d = fg_color;
      end else if (s2_in_bmp_q) begin
        rgb_d = Rdv[s2_bit_q] ? fg_color : bg_color;
      end else begin
        rgb_d = bg_color;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rgb_q    <= '0;
      active_q <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      active_q <= s2_vis_q;
      hsync_q  <= s2_hs_q;
      vsync_q  <= s2_vs_q;
      fs_q     <= s2_fs_q;
    end
  end

  assign av          = av_q;
  assign rgb         = rgb_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire
